// File: rtl/fetch_sequencer.sv
// Program counter owner: next-PC selection, return-address stack and the
// RUN/WAIT_IO/HALT sequencing with a confirm-button handshake.
module fetch_sequencer #(
  parameter int unsigned            ADDR_W    = 32,
  parameter int unsigned            IMEM_AW   = 6,
  parameter int unsigned            RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0]      RESET_PC  = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               hlt,
  input  logic               io_wait,
  input  logic               confirm,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic               jr,
  input  logic               call,
  input  logic               ret,
  input  logic [ADDR_W-1:0]  imm,
  input  logic [ADDR_W-1:0]  jr_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [ADDR_W-1:0]  pc_plus_one,
  output logic [1:0]         state,
  output logic               retire,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned SP_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_IO = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic              confirm_prev;
  logic              confirm_pending;
  logic              retire_q;
  logic              ovf_q;
  logic              unf_q;

  logic              ras_empty;
  logic              ras_full;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] next_pc;
  logic              run_retire;
  logic              ras_we;
  logic [PTR_W-1:0]  ras_widx;
  logic              ovf_set;
  logic              unf_set;

  assign pc            = pc_q;
  assign imem_addr     = pc_q[IMEM_AW-1:0];
  assign pc_plus_one   = pc_q + ADDR_W'(1);
  assign state         = state_q;
  assign retire        = retire_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

  assign ras_empty  = (sp_q == '0);
  assign ras_full   = (sp_q == SP_W'(RAS_DEPTH));
  assign top_idx    = PTR_W'(sp_q - SP_W'(1));
  assign ras_top    = ras[top_idx];
  assign run_retire = enable && (state_q == ST_RUN) && !hlt && !io_wait;

  always_comb begin
    next_pc = pc_plus_one;
    if (ret)
      next_pc = ras_empty ? pc_plus_one : ras_top;
    else if (call)
      next_pc = imm;
    else if (branch_taken)
      next_pc = pc_plus_one + imm;
    else if (jump && jr)
      next_pc = jr_target;
    else if (jump)
      next_pc = imm;
  end

  // Stack bookkeeping; call+ret on a non-empty stack swaps the top in place.
  always_comb begin
    ras_we   = 1'b0;
    ras_widx = top_idx;
    sp_d     = sp_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (run_retire) begin
      if (call && ret) begin
        ras_we = 1'b1;
        if (ras_empty) begin
          ras_widx = PTR_W'(sp_q);
          sp_d     = sp_q + SP_W'(1);
          unf_set  = 1'b1;
        end
      end else if (call) begin
        if (ras_full) begin
          ovf_set = 1'b1;
        end else begin
          ras_we   = 1'b1;
          ras_widx = PTR_W'(sp_q);
          sp_d     = sp_q + SP_W'(1);
        end
      end else if (ret) begin
        if (ras_empty)
          unf_set = 1'b1;
        else
          sp_d = sp_q - SP_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ras_we)
      ras[ras_widx] <= pc_plus_one;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      state_q         <= ST_RUN;
      sp_q            <= '0;
      confirm_prev    <= 1'b0;
      confirm_pending <= 1'b0;
      retire_q        <= 1'b0;
      ovf_q           <= 1'b0;
      unf_q           <= 1'b0;
    end else begin
      confirm_prev <= confirm;
      retire_q     <= 1'b0;
      sp_q         <= sp_d;
      ovf_q        <= ovf_q | ovf_set;
      unf_q        <= unf_q | unf_set;
      if (confirm && !confirm_prev)
        confirm_pending <= 1'b1;
      // Clears below override a same-cycle edge: a press racing the state
      // change is treated as stale or already consumed.
      if (enable) begin
        case (state_q)
          ST_RUN: begin
            if (hlt) begin
              state_q <= ST_HALT;
            end else if (io_wait) begin
              state_q         <= ST_WAIT_IO;
              confirm_pending <= 1'b0;
            end else begin
              pc_q     <= next_pc;
              retire_q <= 1'b1;
            end
          end
          ST_WAIT_IO: begin
            if (confirm_pending) begin
              pc_q            <= pc_plus_one;
              state_q         <= ST_RUN;
              confirm_pending <= 1'b0;
              retire_q        <= 1'b1;
            end
          end
          ST_HALT: ;
          default: state_q <= ST_HALT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed steps push their expected
// pc/state/retire/flags, which are popped and compared after the clock edge.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset, enable, hlt, io_wait, confirm;
  logic        branch_taken, jump, jr, call, ret;
  logic [31:0] imm, jr_target;

  logic [31:0] pc, pc_plus_one, d2_pc, d2_pc_plus_one;
  logic [5:0]  imem_addr, d2_imem_addr;
  logic [1:0]  state, d2_state;
  logic        retire, ras_overflow, ras_underflow;
  logic        d2_retire, d2_ras_overflow, d2_ras_underflow;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  st;
    logic        ret;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   use2  = 1'b0;
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;

  always #5 clock = ~clock;

  fetch_sequencer #(.ADDR_W(32), .IMEM_AW(6), .RAS_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .hlt(hlt), .io_wait(io_wait),
    .confirm(confirm), .branch_taken(branch_taken), .jump(jump), .jr(jr),
    .call(call), .ret(ret), .imm(imm), .jr_target(jr_target),
    .pc(pc), .imem_addr(imem_addr), .pc_plus_one(pc_plus_one), .state(state),
    .retire(retire), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  fetch_sequencer #(.ADDR_W(32), .IMEM_AW(6), .RAS_DEPTH(2), .RESET_PC(32'h0)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .hlt(hlt), .io_wait(io_wait),
    .confirm(confirm), .branch_taken(branch_taken), .jump(jump), .jr(jr),
    .call(call), .ret(ret), .imm(imm), .jr_target(jr_target),
    .pc(d2_pc), .imem_addr(d2_imem_addr), .pc_plus_one(d2_pc_plus_one),
    .state(d2_state), .retire(d2_retire), .ras_overflow(d2_ras_overflow),
    .ras_underflow(d2_ras_underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_flow();
    hlt = 0; io_wait = 0; branch_taken = 0; jump = 0; jr = 0;
    call = 0; ret = 0; imm = '0; jr_target = '0;
  endtask

  task automatic step(input logic en, input logic [31:0] epc,
                      input logic [1:0] est, input logic eret);
    exp_t e;
    enable = en;
    e = '{pc: epc, st: est, ret: eret, ovf: exp_ovf, unf: exp_unf};
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_eq("pc",       use2 ? d2_pc            : pc,            e.pc);
    check_eq("state",    use2 ? d2_state         : state,         32'(e.st));
    check_eq("retire",   use2 ? d2_retire        : retire,        32'(e.ret));
    check_eq("overflow", use2 ? d2_ras_overflow  : ras_overflow,  32'(e.ovf));
    check_eq("underflow",use2 ? d2_ras_underflow : ras_underflow, 32'(e.unf));
    clear_flow();
    enable = 0;
  endtask

  task automatic do_reset();
    reset   = 1;
    exp_ovf = 0;
    exp_unf = 0;
    jump = 1; imm = 32'h77;
    step(1, 32'h0, 2'd0, 1'b0);
    reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; enable = 0; confirm = 0;
    clear_flow();
    @(negedge clock);

    // reset, then sequential advance
    do_reset();
    step(1, 32'd1, 2'd0, 1'b1);
    step(1, 32'd2, 2'd0, 1'b1);
    step(1, 32'd3, 2'd0, 1'b1);
    step(0, 32'd3, 2'd0, 1'b0);

    // branch with negative offset, jump-register, wrap-around
    step(1, 32'd4, 2'd0, 1'b1);
    step(1, 32'd5, 2'd0, 1'b1);
    branch_taken = 1; imm = 32'hFFFF_FFFD;
    step(1, 32'd3, 2'd0, 1'b1);
    jump = 1; jr = 1; jr_target = 32'h20; imm = 32'h99;
    step(1, 32'h20, 2'd0, 1'b1);
    check_eq("imem_addr", 32'(imem_addr), 32'h20);
    check_eq("pc_plus_one", pc_plus_one, 32'h21);
    jump = 1; imm = 32'hFFFF_FFFF;
    step(1, 32'hFFFF_FFFF, 2'd0, 1'b1);
    check_eq("imem_addr_hi", 32'(imem_addr), 32'h3F);
    check_eq("pc_plus_one_wrap", pc_plus_one, 32'h0);
    step(1, 32'h0, 2'd0, 1'b1);

    // call / return / underflow / call+ret swap
    do_reset();
    jump = 1; imm = 32'd4;
    step(1, 32'd4, 2'd0, 1'b1);
    call = 1; imm = 32'h10;
    step(1, 32'h10, 2'd0, 1'b1);
    ret = 1;
    step(1, 32'd5, 2'd0, 1'b1);
    ret = 1; exp_unf = 1;
    step(1, 32'd6, 2'd0, 1'b1);
    call = 1; imm = 32'h30;
    step(1, 32'h30, 2'd0, 1'b1);
    call = 1; ret = 1; imm = 32'h40;
    step(1, 32'd7, 2'd0, 1'b1);
    ret = 1;
    step(1, 32'h31, 2'd0, 1'b1);
    ret = 1;
    step(1, 32'h32, 2'd0, 1'b1);

    // depth-2 stack: third push dropped
    do_reset();
    use2 = 1;
    jump = 1; imm = 32'd1;
    step(1, 32'd1, 2'd0, 1'b1);
    call = 1; imm = 32'd11;
    step(1, 32'd11, 2'd0, 1'b1);
    call = 1; imm = 32'd21;
    step(1, 32'd21, 2'd0, 1'b1);
    call = 1; imm = 32'd31; exp_ovf = 1;
    step(1, 32'd31, 2'd0, 1'b1);
    ret = 1;
    step(1, 32'd12, 2'd0, 1'b1);
    ret = 1;
    step(1, 32'd2, 2'd0, 1'b1);
    ret = 1; exp_unf = 1;
    step(1, 32'd3, 2'd0, 1'b1);
    use2 = 0;

    // io_wait handshake: stale press discarded, fresh press while idle consumed
    do_reset();
    jump = 1; imm = 32'd7;
    step(1, 32'd7, 2'd0, 1'b1);
    confirm = 1;
    step(0, 32'd7, 2'd0, 1'b0);
    confirm = 0;
    step(0, 32'd7, 2'd0, 1'b0);
    io_wait = 1;
    step(1, 32'd7, 2'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      io_wait = 1; jump = 1; imm = 32'h55; call = (i % 2) == 0;
      step(1, 32'd7, 2'd1, 1'b0);
    end
    confirm = 1;
    step(0, 32'd7, 2'd1, 1'b0);
    step(1, 32'd8, 2'd0, 1'b1);
    step(0, 32'd8, 2'd0, 1'b0);
    confirm = 0;

    // halt is absorbing; only reset leaves it
    ret = 1; exp_unf = 1;
    step(1, 32'd9, 2'd0, 1'b1);
    hlt = 1; io_wait = 1;
    step(1, 32'd9, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      jump = 1; imm = 32'h50; call = 1; confirm = (i % 2) == 0;
      step(1, 32'd9, 2'd2, 1'b0);
    end
    confirm = 0;
    do_reset();
    use2 = 1;
    step(0, 32'd0, 2'd0, 1'b0);
    use2 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
